demux1x4_nbit: RTL and testbench
================================

# demux1x4_nbit

Registered 1-to-4 stream demultiplexer: the receiving-side counterpart of the 4:1 `n`-bit select mux. A single `n`-bit input stream is steered by a 2-bit select to one of four output channels. Each channel has its own one-entry holding register, a valid/ready handshake and a wrap-around transfer counter. It sits wherever one shared data path must be fanned back out to four independent consumers.

## Interface
- `n`, default 4: data width.
- `cw`, default 8: width of each per-channel transfer counter.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  input beat accepted this cycle when high together with `in_valid`.
- `in_data`  in  n  input payload.
- `s`  in  2  destination channel for the current input beat, sampled with `in_data`.
- `o0`, `o1`, `o2`, `o3`  out  n each  channel payloads, registered.
- `o_valid`  out  4  bit k means channel k holds a beat.
- `o_ready`  in  4  bit k means consumer k takes the beat this cycle.
- `clr`  in  1  synchronous clear of all counters.
- `cnt`  out  4*cw  channel k counter at bits [k*cw +: cw].

## Operation
- Each channel k has a holding register `full[k]` / `data[k]`. `o_valid[k] = full[k]` and `ok = data[k]`.
- Input acceptance:
  - `in_ready = !full[s] || o_ready[s]`, combinational in `s` and `o_ready`.
  - An input fire (`in_valid && in_ready`) writes `in_data` into `data[s]` and sets `full[s]`.
- Output drain: an output fire on channel k (`full[k] && o_ready[k]`) clears `full[k]`, unless the same cycle also has an input fire into k. In that case `full[k]` stays 1 and `data[k]` takes the new beat (pass-through at full rate).
- Channels not addressed by `s` are never modified by the input. Backpressure on one channel stalls the input only while `s` points at that channel.
- Counter behaviour:
  - `cnt[k]` increments by 1 on each output fire of channel k.
  - It wraps modulo 2^cw; for example, with cw=8, 255 wraps to 0.
  - `clr` forces all counters to 0 and takes priority over increments in the same cycle. `clr` does not affect `full` or `data`.
- While `in_valid` is low, `in_data` and `s` are don't-care. The block holds no other state and has no state machine beyond the four 1-bit `full` flags.
- Reset values: `full` = 0 (so `o_valid` = 4'b0), `data` = 0 (so `o0`..`o3` = 0), all `cnt` = 0. `in_ready` therefore reads 1 out of reset.
- Reset asserted mid-transfer: held beats are discarded immediately and asynchronously, with no partial counts. After deassertion the block behaves exactly as after power-on reset.

## Timing
- Latency: a beat accepted at edge t is visible on `o_valid[s]` and `o_s` after edge t.
- Throughput: one beat per cycle per channel when the consumer holds `o_ready` high.
- Counter update: `cnt` reflects an output fire one edge after that fire.
- Combinational paths: `o_ready` and `s` to `in_ready` is the only combinational input-to-output path. No path runs from `in_valid` to any output.
- Output stability: `o_valid[k]`, once high, stays high with `ok` stable until a fire on k.

## Structure
- Shared package holds:
  - `NUM_CH = 4`
  - `SEL_W = 2`
  - a channel-index typedef `ch_t` of `SEL_W` bits, used by both this block and the 4:1 mux.
- One sub-module, `demux_slot`: a one-entry register slice with load and drain inputs, `full`/`data` outputs and a `cw`-bit wrap counter with clear. The top instantiates it 4 times and contains only the select decode and the `in_ready` mux.

## Test plan
- Reset then idle: `o_valid` = 0000, `o0`..`o3` = 0, `cnt` = 0, `in_ready` = 1. Assert `rst` asynchronously mid-cycle with channel 2 full: `o_valid[2]` drops before the next edge.
- Steering with n=4, all `o_ready` = 1: send 0xA to s=0, 0x5 to s=1, 0xF to s=2, 0x3 to s=3 on back-to-back cycles. Each beat appears on its own channel one cycle later, and each `cnt` = 1.
- Backpressure: with `o_ready[1]` = 0, a beat to ch1 makes `full[1]` = 1, and a second beat to ch1 sees `in_ready` = 0. A beat to ch3 in the next cycle is accepted. Raising `o_ready[1]` accepts the stalled beat in the same cycle it drains.
- Full-rate pass-through: with ch0 full, `o_ready[0]` = 1 and `in_valid` with s=0 every cycle for 10 cycles, `o_valid[0]` stays 1, each payload follows one cycle behind, and `cnt[0]` = 10.
- Counter wrap with cw=8: 256 drains on ch2 return `cnt[2]` to 0. Asserting `clr` in the same cycle as a drain on ch3 leaves `cnt[3]` = 0.

Source files
------------

// File: rtl/demux1x4_nbit_pkg.sv
// Shared channel definitions for the 4-way select mux and demux blocks.
package demux1x4_nbit_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice with valid flag and a wrap-around drain counter.
module demux_slot #(
  parameter int unsigned n  = 4,
  parameter int unsigned cw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [n-1:0]  din,
  input  logic          ready,
  input  logic          clr,
  output logic          full,
  output logic [n-1:0]  data,
  output logic [cw-1:0] cnt
);

  logic          full_q, full_d;
  logic [n-1:0]  data_q, data_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic          drain;

  always_comb begin
    drain  = full_q && ready;
    full_d = full_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    // A load in the same cycle as a drain keeps the slot full (pass-through).
    if (load) begin
      full_d = 1'b1;
      data_d = din;
    end else if (drain) begin
      full_d = 1'b0;
    end
    if (clr) begin
      cnt_d = '0;
    end else if (drain) begin
      cnt_d = cnt_q + cw'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign full = full_q;
  assign data = data_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/demux1x4_nbit.sv
// Registered 1-to-4 stream demultiplexer with per-channel handshake and transfer counters.
module demux1x4_nbit
  import demux1x4_nbit_pkg::*;
#(
  parameter int unsigned n  = 4,
  parameter int unsigned cw = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [n-1:0]         in_data,
  input  ch_t                  s,
  output logic [n-1:0]         o0,
  output logic [n-1:0]         o1,
  output logic [n-1:0]         o2,
  output logic [n-1:0]         o3,
  output logic [NUM_CH-1:0]    o_valid,
  input  logic [NUM_CH-1:0]    o_ready,
  input  logic                 clr,
  output logic [NUM_CH*cw-1:0] cnt
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] load;
  logic [n-1:0]      data [NUM_CH];
  logic              fire;

  // Only the addressed channel can stall the input.
  assign in_ready = !full[s] || o_ready[s];
  assign fire     = in_valid && in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    assign load[k] = fire && (s == ch_t'(k));

    demux_slot #(
      .n  (n),
      .cw (cw)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .din   (in_data),
      .ready (o_ready[k]),
      .clr   (clr),
      .full  (full[k]),
      .data  (data[k]),
      .cnt   (cnt[k*cw +: cw])
    );
  end

  assign o_valid = full;
  assign o0      = data[0];
  assign o1      = data[1];
  assign o2      = data[2];
  assign o3      = data[3];

endmodule

// File: tb/tb_demux1x4_nbit.sv
// Self-checking bench for demux1x4_nbit: directed tables, corner sequences and random traffic.
module tb_demux1x4_nbit;

  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic [1:0]    s = '0;
  logic [N-1:0]  o0, o1, o2, o3;
  logic [3:0]    o_valid;
  logic [3:0]    o_ready = '0;
  logic          clr = 1'b0;
  logic [4*CW-1:0] cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model: each channel is a single-slot buffer plus a drain tally.
  bit        mfull [4];
  int        mdata [4];
  int        mcnt  [4];

  demux1x4_nbit #(.n(N), .cw(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .s        (s),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .clr      (clr),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mfull[k] = 0;
      mdata[k] = 0;
      mcnt[k]  = 0;
    end
  endtask

  function automatic int out_of(input int k);
    case (k)
      0:       return int'(o0);
      1:       return int'(o1);
      2:       return int'(o2);
      default: return int'(o3);
    endcase
  endfunction

  task automatic check_all(input string tag);
    int ov;
    ov = 0;
    for (int k = 0; k < 4; k++) ov += mfull[k] ? (1 << k) : 0;
    chk({tag, " o_valid"}, o_valid, ov);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s o%0d", tag, k), out_of(k), mdata[k]);
      chk($sformatf("%s cnt%0d", tag, k), cnt[k*CW +: CW], mcnt[k]);
    end
    chk({tag, " in_ready"}, in_ready, (!mfull[s] || o_ready[s]) ? 1 : 0);
  endtask

  // Applies one rising edge: model advances on the inputs held across the edge.
  task automatic cycle(input string tag);
    bit       iv, ic;
    int       is, id;
    bit [3:0] ir;
    bit       fire;
    iv = in_valid; is = s; id = in_data; ir = o_ready; ic = clr;
    @(posedge clk);
    fire = iv && (!mfull[is] || ir[is]);
    for (int k = 0; k < 4; k++) begin
      bit drained;
      drained = mfull[k] && ir[k];
      if (ic)           mcnt[k] = 0;
      else if (drained) mcnt[k] = (mcnt[k] + 1) % (1 << CW);
      if (fire && is == k) begin
        mfull[k] = 1;
        mdata[k] = id;
      end else if (drained) begin
        mfull[k] = 0;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input int sel, input int d, input bit [3:0] rdy, input bit c);
    in_valid = v;
    s        = sel[1:0];
    in_data  = d[N-1:0];
    o_ready  = rdy;
    clr      = c;
  endtask

  typedef struct {
    bit       v;
    int       sel;
    int       d;
    bit [3:0] rdy;
    bit [3:0] exp_ov;
    int       exp_out;
  } vec_t;

  vec_t tbl [5];

  initial begin
    // Steering: each beat lands on its own channel and drains the next cycle.
    tbl[0] = '{v: 1, sel: 0, d: 'hA, rdy: 4'hF, exp_ov: 4'b0001, exp_out: 'hA};
    tbl[1] = '{v: 1, sel: 1, d: 'h5, rdy: 4'hF, exp_ov: 4'b0010, exp_out: 'h5};
    tbl[2] = '{v: 1, sel: 2, d: 'hF, rdy: 4'hF, exp_ov: 4'b0100, exp_out: 'hF};
    tbl[3] = '{v: 1, sel: 3, d: 'h3, rdy: 4'hF, exp_ov: 4'b1000, exp_out: 'h3};
    tbl[4] = '{v: 0, sel: 3, d: 'h0, rdy: 4'hF, exp_ov: 4'b0000, exp_out: 'h3};

    model_reset();
    #12 rst = 1'b0;
    #1;
    chk("reset o_valid", o_valid, 0);
    chk("reset cnt", cnt, 0);
    chk("reset in_ready", in_ready, 1);
    check_all("reset");
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].rdy, 0);
      #0;
      chk($sformatf("steer%0d in_ready", i), in_ready, 1);
      cycle($sformatf("steer%0d", i));
      chk($sformatf("steer%0d o_valid tbl", i), o_valid, tbl[i].exp_ov);
      chk($sformatf("steer%0d payload tbl", i), out_of(tbl[i].sel), tbl[i].exp_out);
    end
    for (int k = 0; k < 4; k++) chk($sformatf("steer cnt%0d==1", k), cnt[k*CW +: CW], 1);

    // Backpressure on ch1 stalls only beats addressed to ch1.
    drive(1, 1, 'h7, 4'b1101, 0);
    cycle("bp load1");
    chk("bp full1", o_valid[1], 1);
    drive(1, 1, 'h9, 4'b1101, 0);
    #1 chk("bp stall in_ready", in_ready, 0);
    cycle("bp stalled");
    chk("bp held o1", o1, 'h7);
    drive(1, 3, 'h2, 4'b1101, 0);
    #1 chk("bp ch3 in_ready", in_ready, 1);
    cycle("bp ch3");
    drive(1, 1, 'h9, 4'b1111, 0);
    #1 chk("bp release in_ready", in_ready, 1);
    cycle("bp release");
    chk("bp o1 new", o1, 'h9);
    chk("bp cnt1", cnt[1*CW +: CW], 2);
    drive(0, 0, 0, 4'hF, 0);
    cycle("bp drain");

    // Full-rate pass-through on ch0.
    drive(0, 0, 0, 4'h0, 1);
    cycle("pt clr");
    drive(1, 0, 'h1, 4'h0, 0);
    cycle("pt prefill");
    for (int i = 0; i < 10; i++) begin
      int d;
      d = $urandom_range(15);
      drive(1, 0, d, 4'b0001, 0);
      cycle($sformatf("pt%0d", i));
      chk($sformatf("pt%0d o_valid0", i), o_valid[0], 1);
      chk($sformatf("pt%0d o0", i), o0, d);
    end
    chk("pt cnt0==10", cnt[0 +: CW], 10);

    // Counter wrap: 256 drains on ch2 bring it back to zero.
    drive(0, 0, 0, 4'h0, 1);
    cycle("wrap clr");
    for (int i = 0; i < 257; i++) begin
      drive(1, 2, i % 16, 4'b0100, 0);
      cycle("wrap");
    end
    chk("wrap cnt2==0", cnt[2*CW +: CW], 0);
    drive(1, 3, 'h6, 4'b0000, 0);
    cycle("clr load3");
    drive(0, 0, 0, 4'b1000, 1);
    cycle("clr vs drain3");
    chk("clr cnt3==0", cnt[3*CW +: CW], 0);
    chk("clr drained3", o_valid[3], 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3) != 0, $urandom_range(3), $urandom_range(15),
            4'($urandom_range(15)), $urandom_range(15) == 0);
      cycle("rand");
    end

    // Asynchronous reset mid-cycle with ch2 holding a beat.
    drive(1, 2, 'hC, 4'b0000, 0);
    cycle("arst load2");
    drive(0, 0, 0, 4'b0000, 0);
    chk("arst pre full2", o_valid[2], 1);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst o_valid", o_valid, 0);
    chk("arst o2", o2, 0);
    chk("arst cnt", cnt, 0);
    chk("arst in_ready", in_ready, 1);
    #2 rst = 1'b0;
    drive(1, 1, 'hB, 4'hF, 0);
    cycle("post rst");
    drive(0, 0, 0, 4'hF, 0);
    cycle("post rst drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
